note_tone_gen: RTL and testbench
================================

Name: note_tone_gen

Overview:
- Consumer end of the 4-bit note-code interface driven by the auto-player and keyboard blocks.
- Turns the current note code into a square wave on the piano speaker pin, using a half-period divider counter.
- Applies note changes only at waveform edges, so pitch changes, rests and re-articulations are click-free.
- Sits between the note-source mux and the board audio pin. Also reports playback status for LEDs and debug.

Parameters:
- CLK_HZ, 100000000: system clock frequency. The divisor table below is defined for this value only.
- SIM_SHIFT, 0: right-shift applied to every table divisor, to shorten simulation. Must be 0 in synthesis.
- CNT_W, 18: width of the half-period counter. Must hold 191112.

Ports:
- CLK  input  1  system clock, all logic on the rising edge.
- RESET  input  1  synchronous, active-low reset. Asserted when RESET=0, sampled on the CLK rising edge.
- NOTE  input  4  note code from the source: 0=C5, 1=B, 2=A, 3=G, 4=F, 5=E, 6=D, 7=C4, 8=none/rest, 9..15 invalid. Synchronous to CLK.
- OCTAVE_UP  input  1  1 = divisor halved (one octave up). Sampled together with NOTE.
- MUTE  input  1  1 = SPEAKER forced 0; the counters keep running.
- SPEAKER  output  1  square-wave audio output, registered.
- PLAYING  output  1  1 while an active (non-rest) note is applied.
- CUR_NOTE  output  4  code currently applied to the generator, registered.
- NOTE_START  output  1  one-cycle pulse when a new note or rest is applied.
- BAD_CODE  output  1  sticky flag: an invalid code was seen. Cleared only by reset.

Behaviour:
- Reset (RESET=0 at a clock edge): SPEAKER=0, PLAYING=0, CUR_NOTE=8, NOTE_START=0, BAD_CODE=0, counter=0, pending=0. Reset applied mid-note silences the output on the next edge.
- Half-period divisor table (counts at 100 MHz, before shift): C4=191113, D=170262, E=151686, F=143173, G=127551, A=113636, B=101239, C5=95556.
  - Effective divisor = (table >> SIM_SHIFT) >> OCTAVE_UP.
  - Divisor is latched into a register when the note is applied.
- Input capture: NOTE and OCTAVE_UP are registered once (1-cycle latency).
- Pending request: set when the registered pair differs from the applied CUR_NOTE/octave.
  - A request for a code equal to the one already applied is ignored.
  - Re-articulation of the same note requires the source to pass through 8 first.
- Invalid codes (9..15): BAD_CODE is set the cycle after the code is registered. The code is treated as 8 (rest).
- States:
  - SILENT: PLAYING=0, SPEAKER=0, counter held at 0. A pending request for an active note is applied on the next cycle.
  - TONE: counter increments each cycle. When counter == divisor-1, the counter resets to 0 and SPEAKER toggles; this cycle is the edge point.
  - Pending requests are applied only on the edge point, or on any cycle in SILENT.
- Applying a request:
  - CUR_NOTE and the divisor update, and NOTE_START pulses for 1 cycle.
  - Active note: go to TONE, counter=0, SPEAKER toggled at the edge point, or starts high when entered from SILENT.
  - Rest: go to SILENT and SPEAKER=0. Entered only at an edge point, so a partial pulse is never truncated.
- Transition TONE -> TONE with a new pitch: the current half-period completes, then the new divisor takes effect with no phase discontinuity.
- Simultaneous edge point and new request: the toggle and the apply happen in the same cycle.
- Request superseded before it is applied: the last registered value wins; intermediate codes are dropped without NOTE_START.
- MUTE: gates SPEAKER combinationally before the output register (1-cycle latency). PLAYING and CUR_NOTE are unaffected.
- Latency: from a NOTE change to NOTE_START is at most 2 cycles from SILENT, and at most 2 + current divisor cycles from TONE.

Test Plan:
- Reset, NOTE=8 held -> SPEAKER=0, PLAYING=0, CUR_NOTE=8, no NOTE_START for 1000 cycles.
- SIM_SHIFT=8, NOTE=3 (G) from SILENT -> NOTE_START 2 cycles later, SPEAKER toggles every 498 cycles (127551>>8), PLAYING=1.
- Playing A (divisor 443 at shift 8), switch to C5 mid-period -> the A half-period completes, NOTE_START at that edge, then toggles every 373 cycles.
- Playing E, OCTAVE_UP 0->1 -> at the next edge point the half-period goes from 592 to 296 cycles, with NOTE_START.
- NOTE=12 for 1 cycle while playing D -> BAD_CODE=1 (sticky); rest applied at the edge point, SPEAKER=0, PLAYING=0.
- Hold RESET=0 for 1 cycle during a C4 tone with MUTE toggling -> all outputs at reset values next edge; MUTE=1 earlier forced SPEAKER=0 with CUR_NOTE=7 kept.

Source files
------------

// File: rtl/note_tone_gen.sv
// note_tone_gen: square-wave tone generator fed by the 4-bit note-code bus.
//
// The current note code selects a half-period divisor. A counter runs over
// that divisor and toggles the speaker at each wrap, which is the edge point.
// New codes (pitch, octave, rest) are applied only at an edge point, or at
// once while silent, so the output never carries a truncated pulse.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RESET      in   synchronous active-low reset
//   NOTE[3:0]  in   0=C5 1=B 2=A 3=G 4=F 5=E 6=D 7=C4 8=rest, 9..15 invalid (rest)
//   OCTAVE_UP  in   halve the divisor (one octave up), captured with NOTE
//   MUTE       in   force SPEAKER low, generator keeps running
//   SPEAKER    out  registered square wave
//   PLAYING    out  an active note is applied
//   CUR_NOTE   out  code currently applied
//   NOTE_START out  one-cycle pulse when a note or rest is applied
//   BAD_CODE   out  sticky, an invalid code was captured
module note_tone_gen #(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned SIM_SHIFT = 0,
    parameter int unsigned CNT_W     = 18
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] NOTE,
    input  logic       OCTAVE_UP,
    input  logic       MUTE,
    output logic       SPEAKER,
    output logic       PLAYING,
    output logic [3:0] CUR_NOTE,
    output logic       NOTE_START,
    output logic       BAD_CODE
);

    // The divisor table below is only meaningful at 100 MHz.
    if (CLK_HZ != 100000000 || CNT_W < 18) begin : g_param_check
        $error("note_tone_gen: table needs CLK_HZ=100000000 and CNT_W>=18");
    end

    localparam logic [3:0] RestCode = 4'd8;

    typedef enum logic [0:0] {StSilent, StTone} state_e;

    state_e           state_q;
    logic [3:0]       note_q;      // captured input code
    logic             oct_q;       // captured input octave
    logic [3:0]       cur_note_q;
    logic             cur_oct_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wave_q;      // unmuted waveform
    logic             speaker_q;
    logic             start_q;
    logic             bad_q;

    logic [3:0]       req_note;
    logic             req_rest;
    logic             pending;
    logic             edge_pt;
    logic             apply;
    logic [CNT_W-1:0] new_div;
    logic             wave_d;

    // Half-period counts at 100 MHz.
    function automatic logic [CNT_W-1:0] base_div(input logic [3:0] code);
        logic [17:0] t;
        case (code)
            4'd0:    t = 18'd95556;
            4'd1:    t = 18'd101239;
            4'd2:    t = 18'd113636;
            4'd3:    t = 18'd127551;
            4'd4:    t = 18'd143173;
            4'd5:    t = 18'd151686;
            4'd6:    t = 18'd170262;
            4'd7:    t = 18'd191113;
            default: t = 18'd0;
        endcase
        return CNT_W'(t);
    endfunction

    always_comb begin
        req_note = (note_q > RestCode) ? RestCode : note_q;
        req_rest = (req_note == RestCode);
        // Octave is irrelevant for a rest, so it never re-triggers one.
        pending  = (req_note != cur_note_q) || (!req_rest && (oct_q != cur_oct_q));
        edge_pt  = (state_q == StTone) && (cnt_q == div_q - CNT_W'(1));
        // While silent, CUR_NOTE is the rest code, so a pending request is a note.
        apply    = pending && ((state_q == StSilent) || edge_pt);
        new_div  = (base_div(req_note) >> SIM_SHIFT) >> oct_q;
    end

    always_comb begin
        wave_d = wave_q;
        if (state_q == StSilent) begin
            if (apply) begin
                wave_d = 1'b1;
            end
        end else if (edge_pt) begin
            wave_d = (apply && req_rest) ? 1'b0 : ~wave_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= StSilent;
            note_q     <= RestCode;
            oct_q      <= 1'b0;
            cur_note_q <= RestCode;
            cur_oct_q  <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            wave_q     <= 1'b0;
            speaker_q  <= 1'b0;
            start_q    <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            note_q    <= NOTE;
            oct_q     <= OCTAVE_UP;
            bad_q     <= bad_q | (note_q > RestCode);
            start_q   <= apply;
            wave_q    <= wave_d;
            speaker_q <= wave_d & ~MUTE;

            if (apply) begin
                cur_note_q <= req_note;
                cur_oct_q  <= oct_q;
                div_q      <= new_div;
            end

            unique case (state_q)
                StSilent: begin
                    cnt_q <= '0;
                    if (apply) begin
                        state_q <= StTone;
                    end
                end
                StTone: begin
                    if (edge_pt) begin
                        cnt_q <= '0;
                        if (apply && req_rest) begin
                            state_q <= StSilent;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StSilent;
            endcase
        end
    end

    assign SPEAKER    = speaker_q;
    assign PLAYING    = (state_q == StTone);
    assign CUR_NOTE   = cur_note_q;
    assign NOTE_START = start_q;
    assign BAD_CODE   = bad_q;

endmodule

// File: tb/tb_note_tone_gen.sv
module tb_note_tone_gen;

    localparam int unsigned SHIFT = 8;

    logic       CLK;
    logic       RESET;
    logic [3:0] NOTE;
    logic       OCTAVE_UP;
    logic       MUTE;
    logic       SPEAKER;
    logic       PLAYING;
    logic [3:0] CUR_NOTE;
    logic       NOTE_START;
    logic       BAD_CODE;

    note_tone_gen #(
        .CLK_HZ   (100000000),
        .SIM_SHIFT(SHIFT),
        .CNT_W    (18)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .NOTE      (NOTE),
        .OCTAVE_UP (OCTAVE_UP),
        .MUTE      (MUTE),
        .SPEAKER   (SPEAKER),
        .PLAYING   (PLAYING),
        .CUR_NOTE  (CUR_NOTE),
        .NOTE_START(NOTE_START),
        .BAD_CODE  (BAD_CODE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Half-period in clock cycles for each note code at 100 MHz.
    int unsigned half_tbl[8] = '{95556, 101239, 113636, 127551, 143173, 151686, 170262, 191113};

    function automatic int half_period(input int code, input bit up);
        return int'((half_tbl[code] >> SHIFT) >> up);
    endfunction

    bit m_valid = 0;
    int m_src, m_cur, m_left;
    bit m_src_up, m_up, m_tone, m_wave, m_spk, m_start, m_bad;

    always @(posedge CLK) begin : model
        int req;
        bit pend;
        if (!RESET) begin
            m_valid = 1; m_src = 8; m_src_up = 0; m_cur = 8; m_up = 0; m_tone = 0;
            m_wave = 0; m_left = 0; m_spk = 0; m_start = 0; m_bad = 0;
        end else if (m_valid) begin
            req  = (m_src > 8) ? 8 : m_src;
            pend = (req != m_cur) || (req != 8 && m_src_up != m_up);
            if (m_src > 8) m_bad = 1;
            m_start = 0;
            if (!m_tone) begin
                if (pend) begin
                    m_tone = 1; m_cur = req; m_up = m_src_up; m_wave = 1; m_start = 1;
                    m_left = half_period(req, m_up);
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (pend) begin
                        m_start = 1; m_cur = req; m_up = m_src_up;
                        if (req == 8) begin
                            m_tone = 0; m_wave = 0;
                        end else begin
                            m_wave = !m_wave; m_left = half_period(req, m_up);
                        end
                    end else begin
                        m_wave = !m_wave; m_left = half_period(m_cur, m_up);
                    end
                end
            end
            m_spk    = m_wave & !MUTE;
            m_src    = int'(NOTE);
            m_src_up = OCTAVE_UP;
        end
    end

    always @(negedge CLK) begin
        if (m_valid)
            chk("cycle{spk,play,cur,start,bad}",
                {24'd0, SPEAKER, PLAYING, CUR_NOTE, NOTE_START, BAD_CODE},
                {24'd0, m_spk, m_tone, 4'(m_cur), m_start, m_bad});
    end

    // ---------------- directed helpers ----------------
    task automatic wait_toggle(output int n);
        logic prev;
        prev = SPEAKER;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (SPEAKER == prev && n < 5000);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!NOTE_START && n < 5000);
        chk("note_start_seen", 32'(NOTE_START), 32'd1);
    endtask

    // Count cycles from the current toggle to the next; change inputs mid-period.
    task automatic measure_with_change(input int at, input logic [3:0] nn, input logic up,
                                       output int n, output logic st);
        logic prev;
        prev = SPEAKER;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == at) begin
                NOTE = nn;
                OCTAVE_UP = up;
            end
        end while (SPEAKER == prev && n < 5000);
        st = NOTE_START;
    endtask

    int   n, bad_idle;
    logic st;

    initial begin
        RESET = 1'b0; NOTE = 4'd8; OCTAVE_UP = 1'b0; MUTE = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_cur_note", 32'(CUR_NOTE), 32'd8);
        RESET = 1'b1;

        // Idle with rest held.
        bad_idle = 0;
        repeat (1000) begin
            @(negedge CLK);
            if (SPEAKER || PLAYING || NOTE_START || CUR_NOTE != 4'd8) bad_idle++;
        end
        chk("idle_1000", 32'(bad_idle), 32'd0);

        // G from silent.
        NOTE = 4'd3;
        wait_start(n);
        chk("g_start_latency", 32'(n), 32'd2);
        chk("g_playing", 32'(PLAYING), 32'd1);
        wait_toggle(n); chk("g_half1", 32'(n), 32'd498);
        wait_toggle(n); chk("g_half2", 32'(n), 32'd498);

        // A, then C5 requested mid-period.
        NOTE = 4'd2;
        wait_start(n);
        chk("a_cur_note", 32'(CUR_NOTE), 32'd2);
        measure_with_change(100, 4'd0, 1'b0, n, st);
        chk("a_half_completes", 32'(n), 32'd443);
        chk("c5_start_at_edge", 32'(st), 32'd1);
        wait_toggle(n); chk("c5_half", 32'(n), 32'd373);

        // E, then octave up.
        NOTE = 4'd5;
        wait_start(n);
        measure_with_change(50, 4'd5, 1'b1, n, st);
        chk("e_half", 32'(n), 32'd592);
        chk("e_up_start", 32'(st), 32'd1);
        wait_toggle(n); chk("e_up_half", 32'(n), 32'd296);

        // D, then a one-cycle invalid code followed by rest.
        OCTAVE_UP = 1'b0; NOTE = 4'd6;
        wait_start(n);
        @(negedge CLK); NOTE = 4'd12;
        @(negedge CLK); NOTE = 4'd8;
        @(negedge CLK);
        chk("bad_code_set", 32'(BAD_CODE), 32'd1);
        wait_start(n);
        chk("rest_playing", 32'(PLAYING), 32'd0);
        chk("rest_speaker", 32'(SPEAKER), 32'd0);
        repeat (20) @(negedge CLK);
        chk("bad_code_sticky", 32'(BAD_CODE), 32'd1);

        // C4 with mute, then reset mid-note.
        NOTE = 4'd7;
        wait_start(n);
        MUTE = 1'b1;
        repeat (5) @(negedge CLK);
        chk("mute_speaker", 32'(SPEAKER), 32'd0);
        chk("mute_cur_note", 32'(CUR_NOTE), 32'd7);
        chk("mute_playing", 32'(PLAYING), 32'd1);
        MUTE = 1'b0;
        repeat (3) @(negedge CLK);
        chk("unmute_speaker", 32'(SPEAKER), 32'd1);
        MUTE = 1'b1; @(negedge CLK); MUTE = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_outputs", {27'd0, SPEAKER, PLAYING, NOTE_START, BAD_CODE, 1'b0},
            32'd0);
        chk("rst_cur_note", 32'(CUR_NOTE), 32'd8);
        RESET = 1'b1;

        // Randomized segments, checked by the model every cycle.
        for (int seg = 0; seg < 50; seg++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 6) NOTE = 4'($urandom_range(9, 15));
            else if (r < 25) NOTE = 4'd8;
            else NOTE = 4'($urandom_range(0, 7));
            OCTAVE_UP = 1'($urandom_range(0, 1));
            MUTE = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 29) == 0) begin
                RESET = 1'b0; @(negedge CLK); RESET = 1'b1;
            end
            repeat ($urandom_range(1, 900)) begin
                @(negedge CLK);
                if ($urandom_range(0, 199) == 0) MUTE = ~MUTE;
            end
        end

        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
